// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage.
package pipe_pkg;

  localparam int CTRL_W_DEFAULT = 18;
  localparam int DATA_W_DEFAULT = 185;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with a one-entry skid buffer: a main entry drives
// the outputs, a skid entry absorbs the one word that arrives while the
// downstream stalls, so in_ready can be a pure register.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W            = CTRL_W_DEFAULT,
  parameter int DATA_W            = DATA_W_DEFAULT,
  parameter bit FLUSH_CLEARS_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  stage_state_t      state_reg;
  stage_state_t      state_next;
  logic              in_ready_reg;
  logic [CTRL_W-1:0] main_ctrl_reg;
  logic [DATA_W-1:0] main_data_reg;
  logic [CTRL_W-1:0] skid_ctrl_reg;
  logic [DATA_W-1:0] skid_data_reg;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid & in_ready_reg;
  assign out_xfer = out_valid & out_ready;
  assign in_ready = in_ready_reg;
  assign out_data = main_data_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: flush wins over every handshake in the same cycle.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: if (in_xfer) state_next = ONE;
        ONE: begin
          if (in_xfer && !out_xfer) state_next = FULL;
          else if (!in_xfer && out_xfer) state_next = EMPTY;
        end
        FULL: if (out_xfer) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Outputs decoded from the registered state; ctrl masked as a second
  // guard so a bubble can never carry write enables downstream.
  always_comb begin
    out_valid = (state_reg != EMPTY);
    occupancy = state_reg;
    out_ctrl  = out_valid ? main_ctrl_reg : '0;
  end

  // in_ready is registered from the next state, so it never depends
  // combinationally on out_ready; it stays low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_reg <= 1'b0;
    end else begin
      in_ready_reg <= (state_next != FULL);
    end
  end

  // Main entry: loads from input (empty or draining) or from skid (full);
  // ctrl is zeroed whenever the entry becomes invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ctrl_reg <= '0;
      main_data_reg <= '0;
    end else if (flush) begin
      main_ctrl_reg <= '0;
      if (FLUSH_CLEARS_DATA) main_data_reg <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            main_ctrl_reg <= in_ctrl;
            main_data_reg <= in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_ctrl_reg <= in_ctrl;
            main_data_reg <= in_data;
          end else if (out_xfer) begin
            main_ctrl_reg <= '0;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_ctrl_reg <= skid_ctrl_reg;
            main_data_reg <= skid_data_reg;
          end
        end
        default: main_ctrl_reg <= '0;
      endcase
    end
  end

  // Skid entry: captures the input only when main is held by a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_ctrl_reg <= '0;
      skid_data_reg <= '0;
    end else if (flush) begin
      skid_ctrl_reg <= '0;
      if (FLUSH_CLEARS_DATA) skid_data_reg <= '0;
    end else begin
      case (state_reg)
        ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_ctrl_reg <= in_ctrl;
            skid_data_reg <= in_data;
          end
        end
        FULL: begin
          if (out_xfer) skid_ctrl_reg <= '0;
        end
        default: skid_ctrl_reg <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a default-width instance and a narrow instance
// with flush-clears-data share the handshakes and are compared against a
// queue model of the stage (at most two held words, FIFO order).
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int CW  = CTRL_W_DEFAULT;
  localparam int DW  = DATA_W_DEFAULT;
  localparam int CWB = 4;
  localparam int DWB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic           in_ready_a, out_valid_a;
  logic [CW-1:0]  out_ctrl_a;
  logic [DW-1:0]  out_data_a;
  logic [1:0]     occ_a;
  logic           in_ready_b, out_valid_b;
  logic [CWB-1:0] out_ctrl_b;
  logic [DWB-1:0] out_data_b;
  logic [1:0]     occ_b;
  logic [CWB-1:0] in_ctrl_b;
  logic [DWB-1:0] in_data_b;

  assign in_ctrl_b = in_ctrl[CWB-1:0];
  assign in_data_b = in_data[DWB-1:0];

  always #5 clk = ~clk;

  pipe_stage_skid dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_ctrl(out_ctrl_a), .out_data(out_data_a),
    .flush(flush), .occupancy(occ_a)
  );

  pipe_stage_skid #(.CTRL_W(CWB), .DATA_W(DWB), .FLUSH_CLEARS_DATA(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_ctrl(in_ctrl_b), .in_data(in_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_ctrl(out_ctrl_b), .out_data(out_data_b),
    .flush(flush), .occupancy(occ_b)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  bit   m_ready = 1'b0;
  bit   b_zero = 1'b1;   // narrow instance's main data known to be zero
  int   n_deliv = 0;
  int   dut_xfers = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Downstream transfers seen on the DUT, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid_a && out_ready) dut_xfers++;
  end

  function automatic logic [CW-1:0] exp_ctrl();
    return (q.size() > 0) ? q[0].c : '0;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    return (q.size() > 0) ? q[0].d : '0;
  endfunction

  // One clock: apply the handshake rules to the model queue.
  task automatic step();
    bit   ix, ox;
    ent_t e;
    ix  = in_valid && m_ready;
    ox  = (q.size() > 0) && out_ready;
    e.c = in_ctrl;
    e.d = in_data;
    @(posedge clk);
    if (ox) n_deliv++;
    if (flush) begin
      q.delete();
      b_zero = 1'b1;
    end else begin
      if (ox) void'(q.pop_front());
      if (ix) begin
        q.push_back(e);
        b_zero = 1'b0;
      end
    end
    m_ready = (q.size() < 2);
    #1;
  endtask

  task automatic drive_word(input logic [DW-1:0] d);
    in_data = d;
    in_ctrl = CW'($urandom) | CW'(1);
  endtask

  task automatic drive_random_word();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    drive_word(r[DW-1:0]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid_a); end
    n_checks++; if (out_ctrl_a !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", out_ctrl_a); end
    n_checks++; if (out_data_a !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data_a); end
    n_checks++; if (occ_a !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occ_a); end
    n_checks++; if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b/%b want 0/0", in_ready_a, in_ready_b); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL release_no_edge_ready: got %b want 0", in_ready_a); end
    step();
    n_checks++; if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin n_fail++; $display("FAIL first_edge_ready: got %b/%b want 1/1", in_ready_a, in_ready_b); end
    $display("test_reset done");
  endtask

  task automatic test_streaming();
    logic [DW-1:0] w;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w = DW'(1000 + i);
      drive_word(w);
      step();
      n_checks++; if (out_valid_a !== 1'b1 || out_data_a !== w) begin n_fail++; $display("FAIL stream_word%0d: got v=%b %h want v=1 %h", i, out_valid_a, out_data_a, w); end
      n_checks++; if (out_ctrl_a !== exp_ctrl()) begin n_fail++; $display("FAIL stream_ctrl%0d: got %h want %h", i, out_ctrl_a, exp_ctrl()); end
      n_checks++; if (occ_a !== 2'd1 || occ_b !== 2'd1) begin n_fail++; $display("FAIL stream_occ%0d: got %0d/%0d want 1", i, occ_a, occ_b); end
      n_checks++; if (out_data_b !== w[DWB-1:0]) begin n_fail++; $display("FAIL stream_b_word%0d: got %h want %h", i, out_data_b, w[DWB-1:0]); end
      $display("stream word %0d out=%0d occ=%0d", i, out_data_a, occ_a);
    end
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid_a !== 1'b0 || out_ctrl_a !== '0 || occ_a !== 2'd0) begin n_fail++; $display("FAIL stream_drain: got v=%b c=%h occ=%0d want 0", out_valid_a, out_ctrl_a, occ_a); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] w0, w1;
    w0 = DW'(32'h1111);
    w1 = DW'(32'h2222);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    drive_word(w0);
    step();
    n_checks++; if (occ_a !== 2'd1 || out_data_a !== w0 || in_ready_a !== 1'b1) begin n_fail++; $display("FAIL stall_c1: got occ=%0d d=%h rdy=%b want 1 %h 1", occ_a, out_data_a, in_ready_a, w0); end
    drive_word(w1);
    step();
    n_checks++; if (occ_a !== 2'd2 || out_data_a !== w0 || in_ready_a !== 1'b0) begin n_fail++; $display("FAIL stall_c2: got occ=%0d d=%h rdy=%b want 2 %h 0", occ_a, out_data_a, in_ready_a, w0); end
    drive_word(DW'(32'h3333));
    step();
    n_checks++; if (occ_a !== 2'd2 || out_data_a !== w0 || in_ready_a !== 1'b0 || occ_b !== 2'd2) begin n_fail++; $display("FAIL stall_c3: got occ=%0d d=%h rdy=%b want 2 %h 0", occ_a, out_data_a, in_ready_a, w0); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    n_checks++; if (occ_a !== 2'd1 || out_data_a !== w1 || in_ready_a !== 1'b1 || out_ctrl_a !== exp_ctrl()) begin n_fail++; $display("FAIL stall_release: got occ=%0d d=%h rdy=%b want 1 %h 1", occ_a, out_data_a, in_ready_a, w1); end
    step();
    n_checks++; if (out_valid_a !== 1'b0 || occ_a !== 2'd0) begin n_fail++; $display("FAIL stall_empty: got v=%b occ=%0d want 0 0", out_valid_a, occ_a); end
    $display("test_stall done");
  endtask

  task automatic test_flush_full();
    logic [DW-1:0] w0;
    w0 = DW'(32'h5A5A);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    drive_word(w0);
    step();
    drive_word(DW'(32'h6B6B));
    step();
    n_checks++; if (occ_a !== 2'd2) begin n_fail++; $display("FAIL flush_full_setup: got occ=%0d want 2", occ_a); end
    drive_word(DW'(32'h7C7C));
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (out_valid_a !== 1'b0 || out_ctrl_a !== '0 || occ_a !== 2'd0) begin n_fail++; $display("FAIL flush_full: got v=%b c=%h occ=%0d want 0", out_valid_a, out_ctrl_a, occ_a); end
    n_checks++; if (out_data_a !== w0) begin n_fail++; $display("FAIL flush_keeps_data: got %h want %h", out_data_a, w0); end
    n_checks++; if (out_data_b !== '0 || out_ctrl_b !== '0) begin n_fail++; $display("FAIL flush_clears_data_b: got d=%h c=%h want 0", out_data_b, out_ctrl_b); end
    n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", in_ready_a); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin n_fail++; $display("FAIL flush_ghost%0d: got %b/%b want 0", i, out_valid_a, out_valid_b); end
    end
    $display("test_flush_full done");
  endtask

  task automatic test_flush_out();
    logic [DW-1:0] w0;
    int            x0;
    w0 = DW'(32'h9999);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    drive_word(w0);
    step();
    x0 = dut_xfers;
    out_ready = 1'b1;
    flush     = 1'b1;
    drive_word(DW'(32'hAAAA));
    n_checks++; if (out_valid_a !== 1'b1 || out_data_a !== w0) begin n_fail++; $display("FAIL flush_out_offer: got v=%b d=%h want 1 %h", out_valid_a, out_data_a, w0); end
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (out_valid_a !== 1'b0 || occ_a !== 2'd0) begin n_fail++; $display("FAIL flush_out_after: got v=%b occ=%0d want 0 0", out_valid_a, occ_a); end
    repeat (3) step();
    n_checks++; if (dut_xfers - x0 !== 1) begin n_fail++; $display("FAIL flush_out_count: got %0d transfers want 1", dut_xfers - x0); end
    $display("test_flush_out done");
  endtask

  task automatic test_async_reset();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    drive_random_word();
    step();
    drive_random_word();
    step();
    n_checks++; if (occ_a !== 2'd2) begin n_fail++; $display("FAIL areset_setup: got occ=%0d want 2", occ_a); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    q.delete();
    m_ready = 1'b0;
    b_zero  = 1'b1;
    n_checks++; if (out_valid_a !== 1'b0 || out_ctrl_a !== '0 || out_data_a !== '0 || occ_a !== 2'd0 || in_ready_a !== 1'b0) begin n_fail++; $display("FAIL areset_no_edge: got v=%b c=%h d=%h occ=%0d rdy=%b want 0", out_valid_a, out_ctrl_a, out_data_a, occ_a, in_ready_a); end
    n_checks++; if (out_data_b !== '0 || occ_b !== 2'd0) begin n_fail++; $display("FAIL areset_no_edge_b: got d=%h occ=%0d want 0", out_data_b, occ_b); end
    #1;
    rst_n = 1'b1;
    step();
    n_checks++; if (in_ready_a !== 1'b1 || occ_a !== 2'd0) begin n_fail++; $display("FAIL areset_release: got rdy=%b occ=%0d want 1 0", in_ready_a, occ_a); end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    n_deliv   = 0;
    dut_xfers = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      drive_random_word();
      step();
      n_checks++; if (out_valid_a !== (q.size() > 0) || occ_a !== 2'(q.size())) begin n_fail++; $display("FAIL rand_state%0d: got v=%b occ=%0d want occ=%0d", i, out_valid_a, occ_a, q.size()); end
      n_checks++; if (out_ctrl_a !== exp_ctrl()) begin n_fail++; $display("FAIL rand_ctrl%0d: got %h want %h", i, out_ctrl_a, exp_ctrl()); end
      n_checks++; if (in_ready_a !== m_ready || in_ready_b !== m_ready) begin n_fail++; $display("FAIL rand_ready%0d: got %b/%b want %b", i, in_ready_a, in_ready_b, m_ready); end
      if (q.size() > 0) begin
        n_checks++; if (out_data_a !== exp_data()) begin n_fail++; $display("FAIL rand_data%0d: got %h want %h", i, out_data_a, exp_data()); end
      end
      n_checks++; if (occ_b !== 2'(q.size()) || out_ctrl_b !== exp_ctrl()[CWB-1:0]) begin n_fail++; $display("FAIL rand_b%0d: got occ=%0d c=%h want occ=%0d", i, occ_b, out_ctrl_b, q.size()); end
      if (q.size() > 0 || b_zero) begin
        n_checks++; if (out_data_b !== exp_data()[DWB-1:0]) begin n_fail++; $display("FAIL rand_b_data%0d: got %h want %h", i, out_data_b, exp_data()[DWB-1:0]); end
      end
      $display("rand %0d v=%b r=%b f=%b occ=%0d out_valid=%b", i, in_valid, out_ready, flush, occ_a, out_valid_a);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    n_checks++; if (dut_xfers !== n_deliv) begin n_fail++; $display("FAIL rand_deliveries: got %0d want %0d", dut_xfers, n_deliv); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush_full();
    test_flush_out();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
